// File: rtl/sipo_frame_receiver_if.sv
// sipo_frame_receiver_if
//   Bundles the serial input, the output handshake and the status signals of
//   sipo_frame_receiver.
//   master : the side that supplies serial data and consumes words (bench/system)
//   slave  : the receiver itself
// Signals:
//   serial_in, bit_valid, start : serial bit, its qualifier, frame start strobe
//   parallel_out, out_valid     : assembled word and its valid flag
//   out_ready                   : consumer accepts parallel_out
//   busy, overrun, bit_count    : status (frame in progress, sticky error, bits captured)
interface sipo_frame_receiver_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             serial_in;
  logic             bit_valid;
  logic             start;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output serial_in, bit_valid, start, out_ready,
    input  parallel_out, out_valid, busy, overrun, bit_count
  );

  modport slave (
    input  serial_in, bit_valid, start, out_ready,
    output parallel_out, out_valid, busy, overrun, bit_count
  );
endinterface

// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver
//   Serial-in / parallel-out frame receiver. A start strobe opens a frame,
//   WIDTH qualified bits are shifted in, and the completed word is presented
//   on a valid/ready output register. If the output register is still
//   occupied when a word completes, the word waits in HOLD until it drains.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : sipo_frame_receiver_if.slave (data, handshake and status)
//
// state | meaning
// IDLE  | waiting for start; serial input ignored
// SHIFT | capturing bits of the current frame
// HOLD  | complete word waiting for the output register to free up
module sipo_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  sipo_frame_receiver_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic             can_load;
  logic             last_bit;

  // LSB-first fills from the top so the first bit ends up in bit 0 after
  // WIDTH shifts; MSB-first fills from the bottom.
  always_comb begin
    next_word = '0;
    if (LSB_FIRST) next_word = {bus.serial_in, shift_reg[WIDTH-1:1]};
    else           next_word = {shift_reg[WIDTH-2:0], bus.serial_in};
  end

  assign can_load = !bus.out_valid || bus.out_ready;
  assign last_bit = (bus.bit_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      shift_reg        <= '0;
      bus.parallel_out <= '0;
      bus.out_valid    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.bit_count    <= '0;
    end else begin
      // Handshake drains the output; a load below in the same cycle wins.
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= SHIFT;
            bus.busy      <= 1'b1;
            bus.bit_count <= '0;
            shift_reg     <= '0;
          end
        end

        SHIFT: begin
          if (bus.start) begin
            bus.bit_count <= '0;
            shift_reg     <= '0;
          end else if (bus.bit_valid) begin
            if (last_bit) begin
              bus.bit_count <= '0;
              if (can_load) begin
                bus.parallel_out <= next_word;
                bus.out_valid    <= 1'b1;
                bus.busy         <= 1'b0;
                shift_reg        <= '0;
                state            <= IDLE;
              end else begin
                // shift_reg doubles as the hold register while in HOLD
                shift_reg <= next_word;
                state     <= HOLD;
              end
            end else begin
              shift_reg     <= next_word;
              bus.bit_count <= bus.bit_count + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (bus.start || bus.bit_valid) bus.overrun <= 1'b1;
          if (can_load) begin
            bus.parallel_out <= shift_reg;
            bus.out_valid    <= 1'b1;
            bus.busy         <= 1'b0;
            shift_reg        <= '0;
            state            <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/sipo_frame_receiver.md
SIPO_FRAME_RECEIVER -- requirements
Module: sipo_frame_receiver

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 serial_in  input  1  serial data bit, sampled only when bit_valid=1.
REQ-006 bit_valid  input  1  qualifies serial_in for the current cycle.
REQ-007 start  input  1  frame start strobe.
REQ-008 parallel_out  output  WIDTH  registered assembled word.
REQ-009 out_valid  output  1  registered flag; parallel_out holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts parallel_out when out_valid=1 and out_ready=1.
REQ-011 busy  output  1  high in SHIFT or HOLD.
REQ-012 overrun  output  1  sticky error flag.
REQ-013 bit_count  output  clog2(WIDTH+1)  number of bits captured in the current frame.

Function
REQ-014 FSM states SHIFT SHALL be entered from IDLE on a cycle with start=1; bit_count becomes 0. Any bit_valid in that cycle is discarded.
REQ-015 IDLE SHALL ignore bit_valid and serial_in.
REQ-016 SHIFT, bit_valid=1, start=0: the shift register SHALL take the bit; LSB_FIRST=1 shifts right (new bit into MSB), LSB_FIRST=0 shifts left (new bit into LSB); bit_count increments by 1.
REQ-017 SHIFT, start=1: the frame SHALL restart; the partial word is discarded, bit_count becomes 0, and any bit_valid in that cycle is ignored.
REQ-018 On the edge that samples the WIDTH-th bit, if out_valid=0 or out_ready=1 in that cycle, then parallel_out SHALL load the complete word, out_valid SHALL be 1, the state SHALL return to IDLE, and bit_count SHALL be 0 (zero-cycle added latency).
REQ-019 If out_valid=1 and out_ready=0 on that edge, the complete word SHALL be held internally and the state SHALL become HOLD.
REQ-020 HOLD: when out_valid=0 or out_ready=1, the held word SHALL load into parallel_out with out_valid=1, and the state SHALL become IDLE on that edge.
REQ-021 HOLD: start=1 or bit_valid=1 SHALL set overrun=1; those inputs are otherwise ignored and the held word is preserved.
REQ-022 out_valid=1 with out_ready=1 and no new load SHALL clear out_valid on the next edge; parallel_out keeps its last value.
REQ-023 Simultaneous handshake plus new-word load SHALL leave out_valid=1 with the new word.
REQ-024 overrun SHALL clear only on reset.
REQ-025 bit_count SHALL never exceed WIDTH-1 while in SHIFT.

Reset
REQ-026 reset=1 at a posedge SHALL force the following, regardless of state or other inputs, including mid-frame and in HOLD: state IDLE, parallel_out=0, out_valid=0, busy=0, overrun=0, bit_count=0, internal shift/hold registers=0.
REQ-027 With reset=1, out_ready SHALL NOT be treated as a handshake.

Verification (WIDTH=8)
REQ-028 LSB_FIRST=1: start, then bits 1,0,1,1,0,0,1,0 on consecutive bit_valid cycles, with out_ready=1 -> parallel_out=8'h4D and out_valid=1 on the 8th-bit edge; then out_valid=0 one cycle later.
REQ-029 LSB_FIRST=0: the same stimulus -> parallel_out=8'hB2.
REQ-030 Backpressure: out_ready=0, frames 8'h4D then 8'hFF -> busy=1 in HOLD; an extra start -> overrun=1. Raise out_ready -> 8'hFF appears on the same edge the 8'h4D handshake completes; out_valid stays 1.
REQ-031 Restart: start, bits 1,1,1, then start, then bits 0,0,0,0,0,0,0,1 (LSB_FIRST=1) -> parallel_out=8'h80, and no word is emitted for the aborted frame.
REQ-032 Reset mid-frame: reset after 5 bits -> all outputs 0 on the next edge. A subsequent clean frame of 8'h4D is received correctly.
REQ-033 Gapped input: the 8'h4D bits with random bit_valid=0 gaps (up to 3 cycles) -> parallel_out=8'h4D, and bit_count tracks the captured bits.
